// File: rtl/id_ex_stage_if.sv
// Interface bundling the ID-side inputs, EX/MEM and MEM/WB forwarding sources,
// pipeline control, and the EX-facing outputs of the ID/EX stage.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [4:0]    id_shamt;
  logic          id_var_shamt;
  logic [3:0]    id_alu_op;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;

  logic          exm_reg_write;
  logic [RW-1:0] exm_rd;
  logic [DW-1:0] exm_result;
  logic          mwb_reg_write;
  logic [RW-1:0] mwb_rd;
  logic [DW-1:0] mwb_result;

  logic          ext_stall;
  logic          flush;

  logic          load_use_stall;
  logic          ex_valid;
  logic [DW-1:0] ex_A;
  logic [DW-1:0] ex_T;
  logic [4:0]    ex_shamt;
  logic [3:0]    ex_alu_op;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_rd, id_shamt,
           id_var_shamt, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, exm_reg_write, exm_rd, exm_result, mwb_reg_write,
           mwb_rd, mwb_result, ext_stall, flush,
    input  load_use_stall, ex_valid, ex_A, ex_T, ex_shamt, ex_alu_op, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_rd, id_shamt,
           id_var_shamt, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, exm_reg_write, exm_rd, exm_result, mwb_reg_write,
           mwb_rd, mwb_result, ext_stall, flush,
    output load_use_stall, ex_valid, ex_A, ex_T, ex_shamt, ex_alu_op, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use hazard
// detection, and final shift-amount selection for the EX units.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  logic          r_valid;
  logic [DW-1:0] r_rs_data;
  logic [DW-1:0] r_rt_data;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [RW-1:0] r_rd;
  logic [4:0]    r_shamt;
  logic          r_var_shamt;
  logic [3:0]    r_alu_op;
  logic          r_reg_write;
  logic          r_mem_read;
  logic          r_mem_write;
  logic          r_mem_to_reg;

  logic          w_load_use;
  logic          w_capture;
  logic [DW-1:0] w_fwd_a;
  logic [DW-1:0] w_fwd_t;

  // ext_stall already freezes ID, so the hazard is masked while it is high.
  assign w_load_use = !bus.ext_stall && r_valid && r_mem_read && bus.id_valid &&
                      (r_rd != '0) && ((r_rd == bus.id_rs) || (r_rd == bus.id_rt));

  assign w_capture = !bus.flush && !bus.ext_stall && !w_load_use;

  // EX/MEM is younger than MEM/WB, so it wins; register 0 is never forwarded.
  function automatic logic [DW-1:0] fwd_sel(input logic [RW-1:0] idx,
                                            input logic [DW-1:0] reg_val,
                                            input logic          exm_we,
                                            input logic [RW-1:0] exm_idx,
                                            input logic [DW-1:0] exm_val,
                                            input logic          mwb_we,
                                            input logic [RW-1:0] mwb_idx,
                                            input logic [DW-1:0] mwb_val);
    logic [DW-1:0] sel;
    sel = reg_val;
    if (exm_we && (exm_idx != '0) && (exm_idx == idx))
      sel = exm_val;
    else if (mwb_we && (mwb_idx != '0) && (mwb_idx == idx))
      sel = mwb_val;
    return sel;
  endfunction

  always_comb begin
    w_fwd_a = fwd_sel(r_rs, r_rs_data, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                      bus.mwb_reg_write, bus.mwb_rd, bus.mwb_result);
    w_fwd_t = fwd_sel(r_rt, r_rt_data, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                      bus.mwb_reg_write, bus.mwb_rd, bus.mwb_result);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (bus.flush) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (bus.ext_stall) begin
      r_valid      <= r_valid;
      r_reg_write  <= r_reg_write;
      r_mem_read   <= r_mem_read;
      r_mem_write  <= r_mem_write;
      r_mem_to_reg <= r_mem_to_reg;
    end else if (w_load_use) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else begin
      r_valid      <= bus.id_valid;
      r_reg_write  <= bus.id_reg_write  & bus.id_valid;
      r_mem_read   <= bus.id_mem_read   & bus.id_valid;
      r_mem_write  <= bus.id_mem_write  & bus.id_valid;
      r_mem_to_reg <= bus.id_mem_to_reg & bus.id_valid;
    end
  end

  // Data fields only move on a real capture; bubbles leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_shamt     <= '0;
      r_var_shamt <= 1'b0;
      r_alu_op    <= '0;
    end else if (w_capture) begin
      r_rs_data   <= bus.id_rs_data;
      r_rt_data   <= bus.id_rt_data;
      r_rs        <= bus.id_rs;
      r_rt        <= bus.id_rt;
      r_rd        <= bus.id_rd;
      r_shamt     <= bus.id_shamt;
      r_var_shamt <= bus.id_var_shamt;
      r_alu_op    <= bus.id_alu_op;
    end
  end

  assign bus.load_use_stall = w_load_use;
  assign bus.ex_valid       = r_valid;
  assign bus.ex_A           = w_fwd_a;
  assign bus.ex_T           = w_fwd_t;
  assign bus.ex_shamt       = r_var_shamt ? w_fwd_a[4:0] : r_shamt;
  assign bus.ex_alu_op      = r_alu_op;
  assign bus.ex_rd          = r_rd;
  assign bus.ex_reg_write   = r_reg_write  & r_valid;
  assign bus.ex_mem_read    = r_mem_read   & r_valid;
  assign bus.ex_mem_write   = r_mem_write  & r_valid;
  assign bus.ex_mem_to_reg  = r_mem_to_reg & r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, forwarding priority, sllv shift
// amount, load-use bubble, stall/flush priority, and async reset mid-stall.
module tb_id_ex_stage;

  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SLLV = 4'd9;
  localparam logic [3:0] OP_ADD  = 4'd1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  id_ex_stage_if #(.DW(32), .RW(5)) bus_if ();

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus_if.id_valid = 1'b0; bus_if.id_rs_data = '0; bus_if.id_rt_data = '0;
    bus_if.id_rs = '0; bus_if.id_rt = '0; bus_if.id_rd = '0; bus_if.id_shamt = '0;
    bus_if.id_var_shamt = 1'b0; bus_if.id_alu_op = '0; bus_if.id_reg_write = 1'b0;
    bus_if.id_mem_read = 1'b0; bus_if.id_mem_write = 1'b0; bus_if.id_mem_to_reg = 1'b0;
    bus_if.exm_reg_write = 1'b0; bus_if.exm_rd = '0; bus_if.exm_result = '0;
    bus_if.mwb_reg_write = 1'b0; bus_if.mwb_rd = '0; bus_if.mwb_result = '0;
    bus_if.ext_stall = 1'b0; bus_if.flush = 1'b0;
  endtask

  task automatic drive_lw();
    bus_if.id_valid = 1'b1; bus_if.id_rs = 5'd1; bus_if.id_rs_data = 32'h0000_1000;
    bus_if.id_rt = 5'd8; bus_if.id_rt_data = '0; bus_if.id_rd = 5'd8;
    bus_if.id_shamt = '0; bus_if.id_var_shamt = 1'b0; bus_if.id_alu_op = OP_ADD;
    bus_if.id_reg_write = 1'b1; bus_if.id_mem_read = 1'b1;
    bus_if.id_mem_write = 1'b0; bus_if.id_mem_to_reg = 1'b1;
  endtask

  task automatic drive_dep();
    bus_if.id_valid = 1'b1; bus_if.id_rs = 5'd8; bus_if.id_rs_data = 32'h0000_0011;
    bus_if.id_rt = 5'd9; bus_if.id_rt_data = 32'h0000_0099; bus_if.id_rd = 5'd10;
    bus_if.id_shamt = '0; bus_if.id_var_shamt = 1'b0; bus_if.id_alu_op = OP_ADD;
    bus_if.id_reg_write = 1'b1; bus_if.id_mem_read = 1'b0;
    bus_if.id_mem_write = 1'b0; bus_if.id_mem_to_reg = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    bus_if.id_valid = 1'b1; bus_if.id_reg_write = 1'b1; bus_if.id_rt_data = 32'h0000_1234;
    repeat (3) step();
    checks++; if (bus_if.ex_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", bus_if.ex_valid); end
    checks++; if (bus_if.ex_reg_write !== 1'b0) begin failures++; $display("FAIL rst_reg_write got=%0h exp=0", bus_if.ex_reg_write); end
    checks++; if (bus_if.ex_T !== 32'h0) begin failures++; $display("FAIL rst_T got=%h exp=0", bus_if.ex_T); end
    checks++; if (bus_if.ex_shamt !== 5'd0) begin failures++; $display("FAIL rst_shamt got=%0d exp=0", bus_if.ex_shamt); end
    checks++; if (bus_if.load_use_stall !== 1'b0) begin failures++; $display("FAIL rst_lus got=%0h exp=0", bus_if.load_use_stall); end
    rst_n = 1'b1;
    bus_if.id_rs = 5'd1; bus_if.id_rt = 5'd2; bus_if.id_rd = 5'd3;
    bus_if.id_rt_data = 32'h0000_00F0; bus_if.id_shamt = 5'd4; bus_if.id_alu_op = OP_SLL;
    step();
    checks++; if (bus_if.ex_valid !== 1'b1) begin failures++; $display("FAIL rel_valid got=%0h exp=1", bus_if.ex_valid); end
    checks++; if (bus_if.ex_T !== 32'h0000_00F0) begin failures++; $display("FAIL rel_T got=%h exp=000000f0", bus_if.ex_T); end
    checks++; if (bus_if.ex_shamt !== 5'd4) begin failures++; $display("FAIL rel_shamt got=%0d exp=4", bus_if.ex_shamt); end
    checks++; if (bus_if.ex_alu_op !== OP_SLL) begin failures++; $display("FAIL rel_alu_op got=%0d exp=%0d", bus_if.ex_alu_op, OP_SLL); end
  endtask

  task automatic test_forwarding();
    bus_if.id_valid = 1'b1; bus_if.id_rs = 5'd6; bus_if.id_rs_data = 32'h0000_0066;
    bus_if.id_rt = 5'd5; bus_if.id_rt_data = 32'h0000_0055; bus_if.id_rd = 5'd7;
    bus_if.id_shamt = '0; bus_if.id_alu_op = OP_ADD; bus_if.id_reg_write = 1'b1;
    step();
    bus_if.ext_stall = 1'b1;
    bus_if.exm_reg_write = 1'b1; bus_if.exm_rd = 5'd5; bus_if.exm_result = 32'hAAAA_0001;
    bus_if.mwb_reg_write = 1'b1; bus_if.mwb_rd = 5'd5; bus_if.mwb_result = 32'hBBBB_0002;
    #1;
    checks++; if (bus_if.ex_T !== 32'hAAAA_0001) begin failures++; $display("FAIL fwd_exm_T got=%h exp=aaaa0001", bus_if.ex_T); end
    checks++; if (bus_if.ex_A !== 32'h0000_0066) begin failures++; $display("FAIL fwd_noalias_A got=%h exp=00000066", bus_if.ex_A); end
    bus_if.exm_reg_write = 1'b0;
    #1;
    checks++; if (bus_if.ex_T !== 32'hBBBB_0002) begin failures++; $display("FAIL fwd_mwb_T got=%h exp=bbbb0002", bus_if.ex_T); end
    bus_if.exm_reg_write = 1'b1; bus_if.exm_rd = 5'd0; bus_if.mwb_rd = 5'd0;
    #1;
    checks++; if (bus_if.ex_T !== 32'h0000_0055) begin failures++; $display("FAIL fwd_rd0_T got=%h exp=00000055", bus_if.ex_T); end
    bus_if.exm_reg_write = 1'b0; bus_if.mwb_reg_write = 1'b0;
  endtask

  task automatic test_sllv();
    bus_if.ext_stall = 1'b0;
    bus_if.id_valid = 1'b1; bus_if.id_var_shamt = 1'b1; bus_if.id_rs = 5'd3;
    bus_if.id_rs_data = 32'h0000_0100; bus_if.id_rt = 5'd4; bus_if.id_rt_data = 32'h1;
    bus_if.id_shamt = 5'd2; bus_if.id_alu_op = OP_SLLV;
    step();
    bus_if.ext_stall = 1'b1;
    bus_if.exm_reg_write = 1'b1; bus_if.exm_rd = 5'd3; bus_if.exm_result = 32'h0000_0027;
    #1;
    checks++; if (bus_if.ex_shamt !== 5'd7) begin failures++; $display("FAIL sllv_fwd_shamt got=%0d exp=7", bus_if.ex_shamt); end
    checks++; if (bus_if.ex_A !== 32'h0000_0027) begin failures++; $display("FAIL sllv_fwd_A got=%h exp=00000027", bus_if.ex_A); end
    bus_if.exm_reg_write = 1'b0;
    #1;
    checks++; if (bus_if.ex_shamt !== 5'd0) begin failures++; $display("FAIL sllv_reg_shamt got=%0d exp=0", bus_if.ex_shamt); end
    bus_if.exm_rd = '0; bus_if.id_var_shamt = 1'b0; bus_if.ext_stall = 1'b0;
  endtask

  task automatic test_load_use();
    drive_lw();
    step();
    drive_dep();
    #1;
    checks++; if (bus_if.load_use_stall !== 1'b1) begin failures++; $display("FAIL lu_detect got=%0h exp=1", bus_if.load_use_stall); end
    checks++; if (bus_if.ex_mem_read !== 1'b1) begin failures++; $display("FAIL lu_lw_mem_read got=%0h exp=1", bus_if.ex_mem_read); end
    bus_if.ext_stall = 1'b1;
    #1;
    checks++; if (bus_if.load_use_stall !== 1'b0) begin failures++; $display("FAIL lu_masked got=%0h exp=0", bus_if.load_use_stall); end
    bus_if.ext_stall = 1'b0;
    step();
    checks++; if (bus_if.ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble_valid got=%0h exp=0", bus_if.ex_valid); end
    checks++; if (bus_if.ex_reg_write !== 1'b0) begin failures++; $display("FAIL lu_bubble_rw got=%0h exp=0", bus_if.ex_reg_write); end
    checks++; if (bus_if.ex_mem_read !== 1'b0) begin failures++; $display("FAIL lu_bubble_mr got=%0h exp=0", bus_if.ex_mem_read); end
    checks++; if (bus_if.load_use_stall !== 1'b0) begin failures++; $display("FAIL lu_bubble_lus got=%0h exp=0", bus_if.load_use_stall); end
    bus_if.exm_reg_write = 1'b1; bus_if.exm_rd = 5'd8; bus_if.exm_result = 32'h0000_1000;
    step();
    bus_if.exm_reg_write = 1'b0; bus_if.exm_rd = '0;
    bus_if.mwb_reg_write = 1'b1; bus_if.mwb_rd = 5'd8; bus_if.mwb_result = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus_if.ex_valid !== 1'b1) begin failures++; $display("FAIL lu_enter_valid got=%0h exp=1", bus_if.ex_valid); end
    checks++; if (bus_if.ex_A !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lu_mwb_A got=%h exp=deadbeef", bus_if.ex_A); end
    checks++; if (bus_if.ex_T !== 32'h0000_0099) begin failures++; $display("FAIL lu_T got=%h exp=00000099", bus_if.ex_T); end
    checks++; if (bus_if.ex_rd !== 5'd10) begin failures++; $display("FAIL lu_rd got=%0d exp=10", bus_if.ex_rd); end
    checks++; if (bus_if.ex_reg_write !== 1'b1) begin failures++; $display("FAIL lu_rw got=%0h exp=1", bus_if.ex_reg_write); end
    bus_if.mwb_reg_write = 1'b0; bus_if.mwb_rd = '0;
  endtask

  task automatic test_stall_flush();
    bus_if.ext_stall = 1'b1;
    bus_if.id_rd = 5'd20; bus_if.id_rs_data = 32'h0000_00AA; bus_if.id_rt_data = 32'h0000_00BB;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus_if.ex_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%0h exp=1", i, bus_if.ex_valid); end
      checks++; if (bus_if.ex_A !== 32'h0000_0011) begin failures++; $display("FAIL stall_A[%0d] got=%h exp=00000011", i, bus_if.ex_A); end
      checks++; if (bus_if.ex_T !== 32'h0000_0099) begin failures++; $display("FAIL stall_T[%0d] got=%h exp=00000099", i, bus_if.ex_T); end
      checks++; if (bus_if.ex_rd !== 5'd10) begin failures++; $display("FAIL stall_rd[%0d] got=%0d exp=10", i, bus_if.ex_rd); end
    end
    bus_if.flush = 1'b1;
    step();
    checks++; if (bus_if.ex_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", bus_if.ex_valid); end
    checks++; if (bus_if.ex_reg_write !== 1'b0) begin failures++; $display("FAIL flush_rw got=%0h exp=0", bus_if.ex_reg_write); end
    bus_if.flush = 1'b0; bus_if.ext_stall = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_lw();
    step();
    drive_dep();
    #1;
    checks++; if (bus_if.load_use_stall !== 1'b1) begin failures++; $display("FAIL ar_pre_lus got=%0h exp=1", bus_if.load_use_stall); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.ex_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%0h exp=0", bus_if.ex_valid); end
    checks++; if (bus_if.ex_mem_read !== 1'b0) begin failures++; $display("FAIL ar_mem_read got=%0h exp=0", bus_if.ex_mem_read); end
    checks++; if (bus_if.ex_rd !== 5'd0) begin failures++; $display("FAIL ar_rd got=%0d exp=0", bus_if.ex_rd); end
    checks++; if (bus_if.ex_A !== 32'h0) begin failures++; $display("FAIL ar_A got=%h exp=0", bus_if.ex_A); end
    checks++; if (bus_if.load_use_stall !== 1'b0) begin failures++; $display("FAIL ar_lus got=%0h exp=0", bus_if.load_use_stall); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (bus_if.ex_valid !== 1'b1) begin failures++; $display("FAIL ar_post_valid got=%0h exp=1", bus_if.ex_valid); end
    checks++; if (bus_if.ex_rd !== 5'd10) begin failures++; $display("FAIL ar_post_rd got=%0d exp=10", bus_if.ex_rd); end
    checks++; if (bus_if.ex_A !== 32'h0000_0011) begin failures++; $display("FAIL ar_post_A got=%h exp=00000011", bus_if.ex_A); end
    checks++; if (bus_if.load_use_stall !== 1'b0) begin failures++; $display("FAIL ar_post_lus got=%0h exp=0", bus_if.load_use_stall); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_forwarding();
    test_sllv();
    test_load_use();
    test_stall_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
